// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and op-decode helpers for the HI/LO issue path.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MFHI  = 3'd6,
        MD_MFLO  = 3'd7
    } md_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MWAIT  = 3'd1,
        ST_DSTART = 3'd2,
        ST_DWAIT  = 3'd3,
        ST_COMMIT = 3'd4,
        ST_WR     = 3'd5,
        ST_DRAIN  = 3'd6
    } md_state_t;

    // Signed variants of multiply and divide.
    function automatic logic is_signed(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    // Ops that run through the divider.
    function automatic logic is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Ops that run through the multiplier.
    function automatic logic is_mul(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/muldiv_issue_ctrl_if.sv
// Op handshake from ID/EX plus control/operand bus to the HI/LO multiply-divide unit.
interface muldiv_issue_ctrl_if
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);

    logic             op_valid;
    md_op_t           op_code;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             op_ready;
    logic             stall;
    logic [WIDTH-1:0] md_a;
    logic [WIDTH-1:0] md_b;
    logic             md_signed;
    logic             md_sel;
    logic             md_start;
    logic             md_exe;
    logic             md_hi_we;
    logic             md_lo_we;
    logic             md_busy;
    logic             div_err;

    // Sequencer side.
    modport slave (
        input  op_valid, op_code, op_a, op_b, flush, md_busy,
        output op_ready, stall, md_a, md_b, md_signed, md_sel,
               md_start, md_exe, md_hi_we, md_lo_we, div_err
    );

    // Pipeline / unit side.
    modport master (
        output op_valid, op_code, op_a, op_b, flush, md_busy,
        input  op_ready, stall, md_a, md_b, md_signed, md_sel,
               md_start, md_exe, md_hi_we, md_lo_we, div_err
    );

endinterface

// File: rtl/muldiv_issue_ctrl_md_wait_counter.sv
// Loadable down-counter with zero flag; shared by multiplier latency and divide watchdog.
module md_wait_counter #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero_c
);

    logic [CW-1:0] count;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Issue sequencer between ID/EX and the HI/LO multiply-divide unit.
module muldiv_issue_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_TMO = 64
) (
    input  logic                clk,
    input  logic                rst,
    muldiv_issue_ctrl_if.slave  bus
);

    localparam int unsigned CNT_MAX = (DIV_TMO > MUL_LAT) ? DIV_TMO : MUL_LAT;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    md_state_t        state;
    logic [WIDTH-1:0] md_a;
    logic [WIDTH-1:0] md_b;
    logic             md_signed;
    logic             md_sel;
    logic             md_start;
    logic             md_exe;
    logic             md_hi_we;
    logic             md_lo_we;
    logic             div_err;
    logic             seen_busy;

    logic             op_ready;
    logic             accept;
    logic             cnt_load;
    logic [CW-1:0]    cnt_val;
    logic             cnt_dec;
    logic             cnt_zero;

    // Only IDLE accepts; a flush in IDLE drops whatever is presented that cycle.
    assign op_ready = (state == ST_IDLE);
    assign accept   = bus.op_valid && op_ready && !bus.flush;

    // Counter control: multiplier latency on MULT accept, watchdog armed in DSTART.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = (state == ST_MWAIT) || (state == ST_DWAIT) || (state == ST_DRAIN);
        if (accept && is_mul(bus.op_code)) begin
            cnt_load = 1'b1;
            cnt_val  = CW'(MUL_LAT - 1);
        end else if (state == ST_DSTART) begin
            cnt_load = 1'b1;
            cnt_val  = CW'(DIV_TMO - 1);
        end
    end

    md_wait_counter #(.CW(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero_c   (cnt_zero)
    );

    // Sequencer FSM; every unit-facing pulse is registered on entry to its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            md_a      <= '0;
            md_b      <= '0;
            md_signed <= 1'b0;
            md_sel    <= 1'b0;
            md_start  <= 1'b0;
            md_exe    <= 1'b0;
            md_hi_we  <= 1'b0;
            md_lo_we  <= 1'b0;
            div_err   <= 1'b0;
            seen_busy <= 1'b0;
        end else begin
            md_start <= 1'b0;
            md_exe   <= 1'b0;
            md_hi_we <= 1'b0;
            md_lo_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (bus.op_code)
                            MD_MULT, MD_MULTU: begin
                                md_a      <= bus.op_a;
                                md_b      <= bus.op_b;
                                md_signed <= is_signed(bus.op_code);
                                md_sel    <= 1'b0;
                                state     <= ST_MWAIT;
                            end
                            MD_DIV, MD_DIVU: begin
                                md_a      <= bus.op_a;
                                md_b      <= bus.op_b;
                                md_signed <= is_signed(bus.op_code);
                                md_sel    <= 1'b1;
                                md_start  <= 1'b1;
                                state     <= ST_DSTART;
                            end
                            MD_MTHI: begin
                                md_a     <= bus.op_a;
                                md_hi_we <= 1'b1;
                                state    <= ST_WR;
                            end
                            MD_MTLO: begin
                                md_a     <= bus.op_a;
                                md_lo_we <= 1'b1;
                                state    <= ST_WR;
                            end
                            default: begin
                                // MFHI/MFLO: HI/LO is already settled when we are idle.
                            end
                        endcase
                    end
                end
                ST_MWAIT: begin
                    if (bus.flush) begin
                        state <= ST_IDLE;
                    end else if (cnt_zero) begin
                        md_exe <= 1'b1;
                        state  <= ST_COMMIT;
                    end
                end
                ST_DSTART: begin
                    seen_busy <= 1'b0;
                    state     <= bus.flush ? ST_IDLE : ST_DWAIT;
                end
                ST_DWAIT: begin
                    if (bus.md_busy) begin
                        seen_busy <= 1'b1;
                    end
                    if (bus.flush) begin
                        state <= ST_DRAIN;
                    end else if (seen_busy && !bus.md_busy) begin
                        md_exe <= 1'b1;
                        state  <= ST_COMMIT;
                    end else if (cnt_zero) begin
                        div_err <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    // Divider keeps running after a flush; wait it out so HI/LO is quiet.
                    if (bus.md_busy) begin
                        seen_busy <= 1'b1;
                    end
                    if (seen_busy && !bus.md_busy) begin
                        state <= ST_IDLE;
                    end else if (cnt_zero) begin
                        div_err <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_COMMIT, ST_WR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.op_ready  = op_ready;
    assign bus.stall     = bus.op_valid && !op_ready;
    assign bus.md_a      = md_a;
    assign bus.md_b      = md_b;
    assign bus.md_signed = md_signed;
    assign bus.md_sel    = md_sel;
    assign bus.md_start  = md_start;
    assign bus.md_exe    = md_exe;
    assign bus.md_hi_we  = md_hi_we;
    assign bus.md_lo_we  = md_lo_we;
    assign bus.div_err   = div_err;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench for muldiv_issue_ctrl: mult/div/move sequencing, flush, watchdog, reset.
module tb_muldiv_issue_ctrl;
    import muldiv_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   start_cnt;
    int   exe_cnt;

    muldiv_issue_ctrl_if #(.WIDTH(32)) bus ();

    muldiv_issue_ctrl #(
        .WIDTH   (32),
        .MUL_LAT (2),
        .DIV_TMO (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout: observed no end of test, expected end before 200000");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then check pulse exclusivity and tally pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("pulse_excl",
            32'($countones({bus.md_start, bus.md_exe, bus.md_hi_we, bus.md_lo_we}) <= 1), 32'd1);
        if (bus.md_start === 1'b1) start_cnt++;
        if (bus.md_exe === 1'b1) exe_cnt++;
    endtask

    task automatic drive(input logic v, input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = v;
        bus.op_code  = op;
        bus.op_a     = a;
        bus.op_b     = b;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; start_cnt = 0; exe_cnt = 0;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.md_busy = 1'b0;
        drive(1'b0, MD_MFHI, 32'd0, 32'd0);
        tick();
        tick();

        // Reset state
        chk("rst_md_a", bus.md_a, 32'd0);
        chk("rst_md_b", bus.md_b, 32'd0);
        chk("rst_pulses", {28'd0, bus.md_start, bus.md_exe, bus.md_hi_we, bus.md_lo_we}, 32'd0);
        chk("rst_sel_sgn", {30'd0, bus.md_sel, bus.md_signed}, 32'd0);
        chk("rst_div_err", 32'(bus.div_err), 32'd0);
        chk("rst_ready", 32'(bus.op_ready), 32'd1);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        rst = 1'b0;
        tick();

        // MULT -3 * 5, next op held behind it
        drive(1'b1, MD_MULT, 32'hFFFF_FFFD, 32'd5);
        chk("mult_ready_n", 32'(bus.op_ready), 32'd1);
        chk("mult_stall_n", 32'(bus.stall), 32'd0);
        tick();
        drive(1'b1, MD_MFLO, 32'd0, 32'd0);
        chk("mult_signed", 32'(bus.md_signed), 32'd1);
        chk("mult_sel", 32'(bus.md_sel), 32'd0);
        chk("mult_a", bus.md_a, 32'hFFFF_FFFD);
        chk("mult_b", bus.md_b, 32'd5);
        chk("mult_exe_n1", 32'(bus.md_exe), 32'd0);
        chk("mult_stall_n1", 32'(bus.stall), 32'd1);
        tick();
        chk("mult_exe_n2", 32'(bus.md_exe), 32'd0);
        chk("mult_stall_n2", 32'(bus.stall), 32'd1);
        tick();
        chk("mult_exe_n3", 32'(bus.md_exe), 32'd1);
        chk("mult_stall_n3", 32'(bus.stall), 32'd1);
        chk("mult_a_held", bus.md_a, 32'hFFFF_FFFD);
        chk("mult_signed_held", 32'(bus.md_signed), 32'd1);
        tick();
        chk("mult_exe_n4", 32'(bus.md_exe), 32'd0);
        chk("mflo_ready_n4", 32'(bus.op_ready), 32'd1);
        chk("mflo_stall_n4", 32'(bus.stall), 32'd0);
        tick();
        drive(1'b0, MD_MFHI, 32'd0, 32'd0);
        chk("mflo_stays_idle", 32'(bus.op_ready), 32'd1);
        tick();

        // DIVU 100 / 7 with 33-cycle busy
        start_cnt = 0; exe_cnt = 0;
        drive(1'b1, MD_DIVU, 32'd100, 32'd7);
        chk("divu_ready_n", 32'(bus.op_ready), 32'd1);
        tick();
        drive(1'b0, MD_MFHI, 32'd0, 32'd0);
        chk("divu_start", 32'(bus.md_start), 32'd1);
        chk("divu_sel", 32'(bus.md_sel), 32'd1);
        chk("divu_signed", 32'(bus.md_signed), 32'd0);
        chk("divu_a", bus.md_a, 32'd100);
        chk("divu_b", bus.md_b, 32'd7);
        tick();
        bus.md_busy = 1'b1;
        for (int i = 0; i < 33; i++) begin
            chk("divu_busy_exe", 32'(bus.md_exe), 32'd0);
            chk("divu_busy_ready", 32'(bus.op_ready), 32'd0);
            tick();
        end
        bus.md_busy = 1'b0;
        chk("divu_fall_exe", 32'(bus.md_exe), 32'd0);
        tick();
        chk("divu_exe", 32'(bus.md_exe), 32'd1);
        chk("divu_exe_sel", 32'(bus.md_sel), 32'd1);
        chk("divu_exe_a", bus.md_a, 32'd100);
        tick();
        chk("divu_done_exe", 32'(bus.md_exe), 32'd0);
        chk("divu_done_ready", 32'(bus.op_ready), 32'd1);
        chk("divu_start_cnt", 32'(start_cnt), 32'd1);
        chk("divu_exe_cnt", 32'(exe_cnt), 32'd1);

        // MTLO then MFLO held
        drive(1'b1, MD_MTLO, 32'hDEAD_BEEF, 32'd0);
        chk("mtlo_ready_n", 32'(bus.op_ready), 32'd1);
        tick();
        drive(1'b1, MD_MFLO, 32'd0, 32'd0);
        chk("mtlo_lo_we", 32'(bus.md_lo_we), 32'd1);
        chk("mtlo_hi_we", 32'(bus.md_hi_we), 32'd0);
        chk("mtlo_a", bus.md_a, 32'hDEAD_BEEF);
        chk("mtlo_stall", 32'(bus.stall), 32'd1);
        tick();
        chk("mtlo_lo_we_off", 32'(bus.md_lo_we), 32'd0);
        chk("mflo_ready_n2", 32'(bus.op_ready), 32'd1);
        chk("mflo_stall_n2", 32'(bus.stall), 32'd0);
        tick();

        // MTHI
        drive(1'b1, MD_MTHI, 32'h1234_5678, 32'd0);
        tick();
        drive(1'b0, MD_MFHI, 32'd0, 32'd0);
        chk("mthi_hi_we", 32'(bus.md_hi_we), 32'd1);
        chk("mthi_lo_we", 32'(bus.md_lo_we), 32'd0);
        chk("mthi_a", bus.md_a, 32'h1234_5678);
        tick();
        chk("mthi_off", 32'(bus.md_hi_we), 32'd0);
        chk("mthi_ready", 32'(bus.op_ready), 32'd1);

        // DIV flushed during DWAIT
        exe_cnt = 0;
        drive(1'b1, MD_DIV, 32'd20, 32'hFFFF_FFFC);
        tick();
        drive(1'b0, MD_MFHI, 32'd0, 32'd0);
        chk("divf_start", 32'(bus.md_start), 32'd1);
        chk("divf_signed", 32'(bus.md_signed), 32'd1);
        chk("divf_sel", 32'(bus.md_sel), 32'd1);
        tick();
        bus.md_busy = 1'b1;
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("divf_drain_ready", 32'(bus.op_ready), 32'd0);
            tick();
        end
        bus.md_busy = 1'b0;
        chk("divf_fall_ready", 32'(bus.op_ready), 32'd0);
        tick();
        chk("divf_ready", 32'(bus.op_ready), 32'd1);
        chk("divf_no_exe", 32'(exe_cnt), 32'd0);
        chk("divf_no_err", 32'(bus.div_err), 32'd0);

        // DIV with busy never asserted: watchdog
        exe_cnt = 0;
        drive(1'b1, MD_DIV, 32'd9, 32'd3);
        tick();
        drive(1'b0, MD_MFHI, 32'd0, 32'd0);
        for (int i = 1; i <= 64; i++) begin
            chk("tmo_wait_ready", 32'(bus.op_ready), 32'd0);
            chk("tmo_wait_err", 32'(bus.div_err), 32'd0);
            tick();
        end
        chk("tmo_last_ready", 32'(bus.op_ready), 32'd0);
        chk("tmo_last_err", 32'(bus.div_err), 32'd0);
        tick();
        chk("tmo_err", 32'(bus.div_err), 32'd1);
        chk("tmo_ready", 32'(bus.op_ready), 32'd1);
        chk("tmo_no_exe", 32'(exe_cnt), 32'd0);
        tick();
        chk("tmo_err_sticky", 32'(bus.div_err), 32'd1);

        // Reset during MWAIT
        drive(1'b1, MD_MULTU, 32'd7, 32'd9);
        tick();
        drive(1'b0, MD_MFHI, 32'd0, 32'd0);
        chk("rstm_a", bus.md_a, 32'd7);
        chk("rstm_busy", 32'(bus.op_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstm_md_a", bus.md_a, 32'd0);
        chk("rstm_md_b", bus.md_b, 32'd0);
        chk("rstm_pulses", {28'd0, bus.md_start, bus.md_exe, bus.md_hi_we, bus.md_lo_we}, 32'd0);
        chk("rstm_sel_sgn", {30'd0, bus.md_sel, bus.md_signed}, 32'd0);
        chk("rstm_ready", 32'(bus.op_ready), 32'd1);
        chk("rstm_div_err", 32'(bus.div_err), 32'd0);
        tick();
        chk("rstm_no_exe", 32'(bus.md_exe), 32'd0);

        // Flush in IDLE drops the presented op
        drive(1'b1, MD_MTHI, 32'd55, 32'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        drive(1'b0, MD_MFHI, 32'd0, 32'd0);
        chk("fidle_hi_we", 32'(bus.md_hi_we), 32'd0);
        chk("fidle_a", bus.md_a, 32'd0);
        chk("fidle_ready", 32'(bus.op_ready), 32'd1);

        // Flush in MWAIT suppresses exe
        exe_cnt = 0;
        drive(1'b1, MD_MULT, 32'd2, 32'd3);
        tick();
        drive(1'b0, MD_MFHI, 32'd0, 32'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fmul_ready", 32'(bus.op_ready), 32'd1);
        tick();
        tick();
        chk("fmul_no_exe", 32'(exe_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
